mux3_rr_arbiter: RTL and testbench
==================================

// Module: mux3_rr_arbiter
// PURPOSE
// Round-robin arbiter that shares one downstream resource (e.g. a memory or bus port)
// among three requesters. It generates the SEL code for the 3:1 n-bit select mux on
// that resource's input path, plus one-hot grants. A grant is held for a whole
// transaction, measured in RES_ACK beats, and is capped at BURST_MAX beats when
// another requester is waiting.
// PARAMETERS
// BURST_MAX  8  max RES_ACK beats per grant while another REQ is pending; must be >= 1
// PORTS
// CLK        in   1  clock; all state updates on rising edge
// RST_N      in   1  asynchronous, active-low reset
// REQ        in   3  per-requester request level; bit i = requester i; held until served
// RES_ACK    in   1  resource completed one beat for the granted requester (1-cycle pulse)
// GNT        out  3  one-hot grant, registered; 000 when no grant
// SEL        out  2  select code for the 3:1 mux: 0/1/2 = granted index, 3 = none (mux outputs 0)
// RES_VALID  out  1  request to resource = GNT[idx] & REQ[idx]; combinational from REQ
// BUSY       out  1  high while in GRANT state
// BEHAVIOUR
// - Reset (RST_N=0, asynchronous, takes effect without a clock edge):
//   - state=IDLE, GNT=000, SEL=3, BUSY=0, RES_VALID=0.
//   - rotate pointer PTR=0, beat count CNT=0.
// - Internal state:
//   - PTR in {0,1,2}: highest-priority index for the next arbitration.
//   - CNT: $clog2(BURST_MAX+1) bits.
// - FSM has two states, IDLE and GRANT.
// - IDLE:
//   - If REQ!=000, at the next edge: winner = first set REQ bit scanning PTR, PTR+1, PTR+2 (mod 3).
//     Load GNT=onehot(winner), SEL=winner, CNT=0; go to GRANT.
//   - Latency is exactly 1 cycle from REQ sampled high to GNT/SEL valid.
//   - RES_ACK is ignored in IDLE.
// - GRANT (idx = granted index):
//   - RES_VALID = REQ[idx].
//   - Each RES_ACK increments CNT.
//   - Release at the edge when either condition holds:
//     (a) REQ[idx]==0;
//     (b) RES_ACK && CNT+1==BURST_MAX && another REQ bit is set.
//   - On release: PTR = (idx+1) mod 3, GNT=000, SEL=3, CNT=0; go to IDLE.
//   - A release always inserts one IDLE bubble cycle before the next grant.
//   - Condition (b) with no other requester pending: CNT wraps to 0 and the grant is kept.
//   - RES_ACK in the same cycle REQ[idx] drops: beat accepted, release per (a).
// - Changes on non-granted REQ bits never alter GNT/SEL while in GRANT.
// - SEL only takes values 0..2 in GRANT and is 3 in IDLE. GNT and SEL are always consistent.
// - Fairness: with all three REQ bits held, grants rotate 0,1,2,0,... from reset.
//   No requester waits more than 2 grants.
// TESTING
// - Reset: RST_N=0 mid-cycle -> GNT=000, SEL=3, BUSY=0, RES_VALID=0 immediately, with no edge.
// - Single request: REQ=010 -> next edge GNT=010, SEL=1, RES_VALID=1.
//   Drop REQ -> next edge GNT=000, SEL=3.
// - Rotation: REQ=111 held after reset, each grant dropped after 1 ack.
//   -> SEL sequence 0,3,1,3,2,3,0 (IDLE bubbles between).
// - Burst cap (BURST_MAX=4): REQ=101 held, 4 RES_ACK while GNT=001.
//   -> GNT=000 on the 4th-ack edge, then GNT=100, SEL=2.
// - Lone requester: REQ=001 only, 10 consecutive RES_ACK -> GNT stays 001 and SEL=0 throughout.
// - Reset mid-grant: GNT=010, assert RST_N=0 for 1 cycle then release, REQ=111.
//   -> grant order restarts at requester 0 (PTR reset).

Source files
------------

// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter
// Round-robin arbiter sharing one downstream resource among three requesters.
// It drives the select code for the 3:1 input mux and a one-hot grant.
// A grant lasts for the whole transaction, counted in res_ack beats. When
// another requester is waiting, the grant is cut off after BURST_MAX beats.
// After every release there is one idle cycle before the next grant.
module mux3_rr_arbiter #(
    parameter int BURST_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       res_ack,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       res_valid,
    output logic       busy
);

    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [CW-1:0] cnt;

    logic          win_found;
    logic [1:0]    win_idx;
    logic          others_pending;
    logic          cap_hit;
    logic          release_now;
    logic [1:0]    next_ptr;

    // Reduces 0..4 modulo 3 so that the scan wraps past requester 2
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        logic [2:0] t;
        t = (v >= 3'd3) ? (v - 3'd3) : v;
        return t[1:0];
    endfunction

    // The request goes to the resource only while the granted requester is still asking
    assign res_valid = |(gnt & req);

    // Scans the requests starting at the rotate pointer and takes the first set bit
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!win_found && req[wrap3({1'b0, ptr} + 3'(k))]) begin
                win_found = 1'b1;
                win_idx   = wrap3({1'b0, ptr} + 3'(k));
            end
        end
    end

    // Release happens when the owner drops its request, or when the burst cap is reached while another requester waits
    always_comb begin
        others_pending = |(req & ~gnt);
        cap_hit        = (int'(cnt) + 1) == BURST_MAX;
        release_now    = !res_valid || (res_ack && cap_hit && others_pending);
        next_ptr       = (sel == 2'd2) ? 2'd0 : (sel + 2'd1);
    end

    // Two-state grant FSM with registered grant, select and busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 3'b000;
            sel   <= 2'd3;
            busy  <= 1'b0;
            ptr   <= 2'd0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state <= GRANT;
                        gnt   <= 3'b001 << win_idx;
                        sel   <= win_idx;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state <= IDLE;
                        gnt   <= 3'b000;
                        sel   <= 2'd3;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        ptr   <= next_ptr;
                    end else if (res_ack) begin
                        cnt <= cap_hit ? '0 : (cnt + 1'b1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Testbench for mux3_rr_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the owner, beat count and rotate pointer.
module tb_mux3_rr_arbiter;

    localparam int BURST_MAX = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] req = 3'b000;
    logic       res_ack = 1'b0;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       res_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int m_owner;
    int m_ptr;
    int m_beats;

    mux3_rr_arbiter #(.BURST_MAX(BURST_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .res_ack   (res_ack),
        .gnt       (gnt),
        .sel       (sel),
        .res_valid (res_valid),
        .busy      (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
    endfunction

    // One clock edge of the arbitration rules applied to the sampled inputs
    function automatic void model_step(input logic [2:0] r, input logic a);
        bit others;
        if (m_owner < 0) begin
            for (int k = 0; k < 3; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 3]) begin
                    m_owner = (m_ptr + k) % 3;
                    m_beats = 0;
                end
            end
        end else begin
            others = (r & ~(3'b001 << m_owner)) != 3'b000;
            if (a) m_beats++;
            if (!r[m_owner] || (a && m_beats == BURST_MAX && others)) begin
                m_ptr   = (m_owner + 1) % 3;
                m_owner = -1;
                m_beats = 0;
            end else if (m_beats == BURST_MAX) begin
                m_beats = 0;
            end
        end
    endfunction

    // Expected {gnt, sel, busy, res_valid} for the model state and current inputs
    function automatic logic [6:0] model_out();
        logic [2:0] g;
        logic [1:0] s;
        logic       b;
        logic       v;
        g = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
        s = (m_owner < 0) ? 2'd3 : 2'(m_owner);
        b = (m_owner >= 0);
        v = (m_owner >= 0) && req[m_owner];
        return {g, s, b, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(req, res_ack);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = 3'b000;
        res_ack = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        req   = 3'b111;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({gnt, sel, busy, res_valid} !== 7'b000_11_0_0) begin
            errors++;
            $display("[TB] FAIL reset_async: got %b expected %b", {gnt, sel, busy, res_valid}, 7'b000_11_0_0);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({gnt, sel, busy, res_valid} !== 7'b000_11_0_0) begin
            errors++;
            $display("[TB] FAIL reset_held: got %b expected %b", {gnt, sel, busy, res_valid}, 7'b000_11_0_0);
        end
        req = 3'b000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req = 3'b010;
        #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle_valid: got %b expected 0", res_valid);
        end
        tick();
        checks++;
        if ({gnt, sel, busy, res_valid} !== 7'b010_01_1_1) begin
            errors++;
            $display("[TB] FAIL single_grant: got %b expected %b", {gnt, sel, busy, res_valid}, 7'b010_01_1_1);
        end
        req = 3'b000;
        #1;
        checks++;
        if ({gnt, sel, busy, res_valid} !== 7'b010_01_1_0) begin
            errors++;
            $display("[TB] FAIL single_drop_comb: got %b expected %b", {gnt, sel, busy, res_valid}, 7'b010_01_1_0);
        end
        tick();
        checks++;
        if ({gnt, sel, busy, res_valid} !== 7'b000_11_0_0) begin
            errors++;
            $display("[TB] FAIL single_release: got %b expected %b", {gnt, sel, busy, res_valid}, 7'b000_11_0_0);
        end
    endtask

    task automatic test_rotation();
        int exp_sel [7];
        exp_sel = '{0, 3, 1, 3, 2, 3, 0};
        do_reset();
        req = 3'b111;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (sel !== 2'(exp_sel[i]) || {gnt, sel, busy, res_valid} !== model_out()) begin
                errors++;
                $display("[TB] FAIL rotation step %0d: got sel=%0d vec=%b expected sel=%0d vec=%b",
                         i, sel, {gnt, sel, busy, res_valid}, exp_sel[i], model_out());
            end
            if (sel != 2'd3) begin
                res_ack  = 1'b1;
                req[sel] = 1'b0;
            end else begin
                res_ack = 1'b0;
                req     = 3'b111;
            end
        end
        res_ack = 1'b0;
    endtask

    task automatic test_burst_cap();
        do_reset();
        req = 3'b101;
        tick();
        checks++;
        if (gnt !== 3'b001 || sel !== 2'd0) begin
            errors++;
            $display("[TB] FAIL burst_first_grant: got gnt=%b sel=%0d expected gnt=001 sel=0", gnt, sel);
        end
        res_ack = 1'b1;
        for (int b = 1; b <= BURST_MAX; b++) begin
            tick();
            checks++;
            if (gnt !== ((b < BURST_MAX) ? 3'b001 : 3'b000)) begin
                errors++;
                $display("[TB] FAIL burst_beat %0d: got gnt=%b expected %b", b, gnt,
                         (b < BURST_MAX) ? 3'b001 : 3'b000);
            end
        end
        res_ack = 1'b0;
        tick();
        checks++;
        if ({gnt, sel, busy, res_valid} !== 7'b100_10_1_1) begin
            errors++;
            $display("[TB] FAIL burst_handover: got %b expected %b", {gnt, sel, busy, res_valid}, 7'b100_10_1_1);
        end
    endtask

    task automatic test_lone_requester();
        do_reset();
        req = 3'b001;
        tick();
        res_ack = 1'b1;
        for (int b = 1; b <= 10; b++) begin
            tick();
            checks++;
            if ({gnt, sel, busy, res_valid} !== 7'b001_00_1_1) begin
                errors++;
                $display("[TB] FAIL lone_beat %0d: got %b expected %b", b, {gnt, sel, busy, res_valid}, 7'b001_00_1_1);
            end
        end
        res_ack = 1'b0;
        req     = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 3'b010;
        tick();
        checks++;
        if (gnt !== 3'b010) begin
            errors++;
            $display("[TB] FAIL midreset_pre: got gnt=%b expected 010", gnt);
        end
        req = 3'b111;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({gnt, sel, busy, res_valid} !== 7'b000_11_0_0) begin
            errors++;
            $display("[TB] FAIL midreset_async: got %b expected %b", {gnt, sel, busy, res_valid}, 7'b000_11_0_0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({gnt, sel, busy, res_valid} !== 7'b001_00_1_1) begin
            errors++;
            $display("[TB] FAIL midreset_restart: got %b expected %b", {gnt, sel, busy, res_valid}, 7'b001_00_1_1);
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            res_ack = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({gnt, sel, busy, res_valid} !== model_out()) begin
                errors++;
                $display("[TB] FAIL random_comb cycle %0d: got %b expected %b", c, {gnt, sel, busy, res_valid}, model_out());
            end
            tick();
            checks++;
            if ({gnt, sel, busy, res_valid} !== model_out()) begin
                errors++;
                $display("[TB] FAIL random_edge cycle %0d: got %b expected %b", c, {gnt, sel, busy, res_valid}, model_out());
            end
        end
        req     = 3'b000;
        res_ack = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_burst_cap();
        test_lone_requester();
        test_reset_mid_grant();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
